// File: rtl/clock_time_core_pkg.sv
// Shared types and constants for the HH:MM:SS time-of-day core.
// Set-mode FSM encoding, BCD moduli and a binary-to-BCD helper.
package clock_time_core_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  localparam int MOD_60 = 60;
  localparam int MOD_24 = 24;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

endpackage

// File: rtl/clock_time_core_bcd_mod_counter.sv
// Two-digit BCD counter, 00..MODULO-1, with clear and carry-out.
// Ports: CLK, RST (async low), CLR, INC, Q[7:0] {tens,ones}, CO.
module bcd_mod_counter
  import clock_time_core_pkg::*;
#(
  parameter int MODULO = MOD_60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       INC,
  output logic [7:0] Q,
  output logic       CO
);

  localparam logic [7:0] QMAX = to_bcd(MODULO - 1);

  logic [3:0] ones;
  logic [3:0] tens;
  logic       wrap;
  logic [7:0] q_nxt;

  assign ones = Q[3:0];
  assign tens = Q[7:4];

  // Packed BCD orders like binary while digits are valid, so a plain
  // compare finds the top value; bad digits also fold back to 00.
  assign wrap = (ones > 4'd9) || (tens > 4'd9) || (Q >= QMAX);

  always_comb begin
    q_nxt = Q;
    if (wrap) begin
      q_nxt = 8'h00;
    end else if (ones == 4'd9) begin
      q_nxt = {tens + 4'd1, 4'd0};
    end else begin
      q_nxt = {tens, ones + 4'd1};
    end
  end

  assign CO = INC && (Q == QMAX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Q <= 8'h00;
    end else if (CLR) begin
      Q <= 8'h00;
    end else if (INC) begin
      Q <= q_nxt;
    end
  end

endmodule

// File: rtl/clock_time_core.sv
// Time-of-day core: BCD HH:MM:SS, MODE/UP set FSM, 2 Hz field blink.
// Ports: CLK, RST, EN1HZ, SIG2HZ, MODE_BTN, UP_BTN -> *_BCD, BLANK_*, DAY_PULSE.
module clock_time_core
  import clock_time_core_pkg::*;
#(
  parameter int HOUR_MODULO = MOD_24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       SIG2HZ,
  input  logic       MODE_BTN,
  input  logic       UP_BTN,
  output logic [7:0] HOUR_BCD,
  output logic [7:0] MIN_BCD,
  output logic [7:0] SEC_BCD,
  output logic       BLANK_H,
  output logic       BLANK_M,
  output logic       DAY_PULSE
);

  state_t state;

  logic run;
  logic set_h;
  logic set_m;
  logic tick;
  logic up_ok;
  logic sec_clr;
  logic sec_co;
  logic min_inc;
  logic min_co;
  logic hour_inc;
  logic hour_co;

  assign run   = (state == ST_RUN);
  assign set_h = (state == ST_SET_HOUR);
  assign set_m = (state == ST_SET_MIN);

  // MODE always wins: it discards a same-cycle tick or UP press.
  assign tick    = run & EN1HZ & ~MODE_BTN;
  assign up_ok   = UP_BTN & ~MODE_BTN;
  assign sec_clr = run & MODE_BTN;

  assign min_inc  = (tick & sec_co) | (set_m & up_ok);
  assign hour_inc = (tick & min_co) | (set_h & up_ok);

  bcd_mod_counter #(.MODULO(MOD_60)) u_sec (
    .CLK (CLK),
    .RST (RST),
    .CLR (sec_clr),
    .INC (tick),
    .Q   (SEC_BCD),
    .CO  (sec_co)
  );

  bcd_mod_counter #(.MODULO(MOD_60)) u_min (
    .CLK (CLK),
    .RST (RST),
    .CLR (1'b0),
    .INC (min_inc),
    .Q   (MIN_BCD),
    .CO  (min_co)
  );

  bcd_mod_counter #(.MODULO(HOUR_MODULO)) u_hour (
    .CLK (CLK),
    .RST (RST),
    .CLR (1'b0),
    .INC (hour_inc),
    .Q   (HOUR_BCD),
    .CO  (hour_co)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_RUN;
      BLANK_H   <= 1'b0;
      BLANK_M   <= 1'b0;
      DAY_PULSE <= 1'b0;
    end else begin
      BLANK_H   <= set_h & SIG2HZ;
      BLANK_M   <= set_m & SIG2HZ;
      // Hour wrap in set mode is not a day rollover.
      DAY_PULSE <= hour_co & tick;
      if (MODE_BTN) begin
        unique case (state)
          ST_RUN:      state <= ST_SET_HOUR;
          ST_SET_HOUR: state <= ST_SET_MIN;
          default:     state <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_time_core.sv
// Scoreboard bench for clock_time_core against an integer time model.
// Directed set/rollover/reset scenarios followed by random stimulus.
module tb_clock_time_core;

  localparam int HM = 24;

  logic       clk;
  logic       rst_n;
  logic       en1hz;
  logic       sig2hz;
  logic       mode_btn;
  logic       up_btn;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       blank_h;
  logic       blank_m;
  logic       day_pulse;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       bh;
    logic       bm;
    logic       dp;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ent_t;

  ent_t sb[$];
  ent_t me;
  obs_t got;

  int cyc;
  int tests;
  int fails;

  // Model: 0 = running, 1 = setting hours, 2 = setting minutes
  int mh, mm, ms, mst;

  clock_time_core #(.HOUR_MODULO(HM)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .EN1HZ     (en1hz),
    .SIG2HZ    (sig2hz),
    .MODE_BTN  (mode_btn),
    .UP_BTN    (up_btn),
    .HOUR_BCD  (hour_bcd),
    .MIN_BCD   (min_bcd),
    .SEC_BCD   (sec_bcd),
    .BLANK_H   (blank_h),
    .BLANK_M   (blank_m),
    .DAY_PULSE (day_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r = 8'((v / 10) * 16 + (v % 10));
    return r;
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o = {hour_bcd, min_bcd, sec_bcd, blank_h, blank_m, day_pulse};
    return o;
  endfunction

  task automatic report(input string name, input obs_t g, input obs_t e);
    $display("FAIL %s cyc=%0d got %h:%h:%h bh=%b bm=%b dp=%b want %h:%h:%h bh=%b bm=%b dp=%b",
             name, cyc, g.h, g.m, g.s, g.bh, g.bm, g.dp,
             e.h, e.m, e.s, e.bh, e.bm, e.dp);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me  = sb.pop_front();
      got = cur_obs();
      tests++;
      if (me.cyc != cyc) begin
        fails++;
        report("stale_entry", got, me.o);
      end else if (got !== me.o) begin
        fails++;
        report("scoreboard", got, me.o);
      end
    end
  end

  // Inputs set here are sampled at the next rising edge.
  task automatic step(input logic mo, input logic up, input logic en);
    obs_t e;
    int   nst;
    @(posedge clk);
    #1;
    if ($urandom_range(0, 3) == 0) sig2hz = ~sig2hz;
    mode_btn = mo;
    up_btn   = up;
    en1hz    = en;
    e.bh = (mst == 1) && sig2hz;
    e.bm = (mst == 2) && sig2hz;
    e.dp = 1'b0;
    nst  = mst;
    if (mo) begin
      if (mst == 0) ms = 0;
      nst = (mst + 1) % 3;
    end else if (mst == 0) begin
      if (en) begin
        ms = ms + 1;
        if (ms == 60) begin
          ms = 0;
          mm = mm + 1;
          if (mm == 60) begin
            mm = 0;
            mh = mh + 1;
            if (mh == HM) begin
              mh   = 0;
              e.dp = 1'b1;
            end
          end
        end
      end
    end else if (up) begin
      if (mst == 1) mh = (mh + 1) % HM;
      else          mm = (mm + 1) % 60;
    end
    mst = nst;
    e.h = bcd(mh);
    e.m = bcd(mm);
    e.s = bcd(ms);
    sb.push_back('{cyc + 1, e});
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    obs_t z;
    z = '0;
    got = cur_obs();
    tests++;
    if (got !== z) begin
      fails++;
      report(name, got, z);
    end
  endtask

  task automatic hard_reset();
    step(1'b0, 1'b0, 1'b0);
    drain();
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    mh = 0; mm = 0; ms = 0; mst = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en1hz = 1'b0;
    sig2hz = 1'b0;
    mode_btn = 1'b0;
    up_btn = 1'b0;
    mh = 0; mm = 0; ms = 0; mst = 0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_state");
    rst_n = 1'b1;

    // 10 ticks with idle gaps
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end

    // Preload 23:59:59 then roll the day
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 23; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Hour set: 25 UPs wrap to 01, blink on hours only
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end

    // Minute set: 61 UPs, ticks frozen
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 61; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    // Simultaneous events
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Reset mid SET_MIN at 12:34:00
    step(1'b1, 1'b0, 1'b0);
    while (mh != 12) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    while (mm != 34) step(1'b0, 1'b1, 1'b0);
    hard_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0);
      if (i == 2000) hard_reset();
    end

    step(1'b0, 1'b0, 1'b0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
